// File: rtl/apb_regfile_completer.sv
// ============================================================================
// apb_regfile_completer
//
// APB3 completer that terminates the bridge's APB master bus. It holds a small
// word-addressed register file and is the bridge's reference peripheral.
//
//   index 0            ID      read-only constant ID_VALUE; writes ignored
//   index 1            STATUS  write-1-to-clear, set by hw_event bits
//   index 2            IRQ_EN  read/write interrupt enable mask
//   index 3..NUM_REGS-1        general read/write (index 3 drives ctrl_out)
//
// A misaligned address or a word index at or beyond NUM_REGS is answered with
// PSLVERR=1 and PRDATA=0, and no register changes.
//
// Ports
//   pclk       APB clock, the only clock
//   preset     synchronous active-high reset
//   PADDR      byte address, word index = PADDR[31:2]
//   PSEL       completer select
//   PENABLE    access phase
//   PWRITE     1 = write, 0 = read
//   PWDATA     write data
//   PRDATA     read data, meaningful only while PREADY=1
//   PREADY     transfer complete (registered, one cycle wide)
//   PSLVERR    error response, meaningful only while PREADY=1
//   hw_event   event bits OR-ed into STATUS every cycle
//   irq        registered |(STATUS & IRQ_EN)
//   ctrl_out   current value of register 3
//   dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
// Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0) seen in
// IDLE; address, direction and write data are captured there and the master
// must hold PSEL high until PREADY=1. PREADY is high for exactly one cycle and
// PRDATA/PSLVERR are only meaningful in that cycle. PSEL falling before
// PREADY aborts the transfer without side effects. PENABLE is only used to
// recognise the setup cycle; a PENABLE drop mid-access is tolerated.
//
// Timing with WAIT_STATES=N: setup in cycle T0, PREADY=1 in cycle T0+N+2.
// ============================================================================
module apb_regfile_completer #(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic [31:0] PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic [31:0] hw_event,
    output logic        irq,
    output logic [31:0] ctrl_out,
    output logic [1:0]  dbg_state
);

    localparam int IDX_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Transfer captured in the setup cycle
    logic [31:0] addr_q;
    logic        pwrite_q;
    logic [31:0] wdata_q;

    // Register file. Entry 0 is unused storage (ID is a constant), entry 1 is
    // STATUS, entry 2 is IRQ_EN, the rest are general purpose.
    logic [31:0] rf_q [NUM_REGS];

    // ------------------------------------------------------------------------
    // Decode of the captured address
    // ------------------------------------------------------------------------
    logic             addr_err;
    logic [IDX_W-1:0] idx;
    logic [31:0]      read_val;

    always_comb begin
        addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(NUM_REGS));
        idx      = addr_q[IDX_W+1:2];
    end

    // Value returned on the commit edge: zero for writes and errors. It is
    // taken from the registers as they stand before that edge.
    always_comb begin
        read_val = '0;
        if (!pwrite_q && !addr_err) begin
            if (idx == '0) begin
                read_val = ID_VALUE;
            end else begin
                read_val = rf_q[idx];
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------------
    logic latch_en;
    logic commit;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        commit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    latch_en = 1'b1;
                    cnt_d    = 4'(WAIT_STATES);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Loss of PSEL takes priority over everything else: the
                // master gave up, so nothing is committed.
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Response and register updates
    // ------------------------------------------------------------------------
    logic        wr_en;
    logic [31:0] w1c_mask;
    logic [31:0] status_d;
    logic [31:0] irq_en_d;
    logic        irq_d;
    logic        pready_d;
    logic        pslverr_d;
    logic [31:0] prdata_d;

    always_comb begin
        wr_en     = commit && pwrite_q && !addr_err;
        w1c_mask  = (wr_en && idx == IDX_W'(1)) ? wdata_q : 32'h0;
        // A hardware event wins over a same-cycle software clear of that bit.
        status_d  = (rf_q[1] & ~w1c_mask) | hw_event;
        irq_en_d  = (wr_en && idx == IDX_W'(2)) ? wdata_q : rf_q[2];
        // irq follows the values the registers take on this edge.
        irq_d     = |(status_d & irq_en_d);
        pready_d  = commit;
        pslverr_d = commit && addr_err;
        prdata_d  = commit ? read_val : 32'h0;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 32'h0;
            pwrite_q <= 1'b0;
            wdata_q  <= 32'h0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            PRDATA   <= 32'h0;
            irq      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= 32'h0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                addr_q   <= PADDR;
                pwrite_q <= PWRITE;
                wdata_q  <= PWDATA;
            end
            PREADY  <= pready_d;
            PSLVERR <= pslverr_d;
            PRDATA  <= prdata_d;
            irq     <= irq_d;
            rf_q[0] <= 32'h0;
            rf_q[1] <= status_d;
            rf_q[2] <= irq_en_d;
            for (int i = 3; i < NUM_REGS; i++) begin
                if (wr_en && idx == IDX_W'(i)) begin
                    rf_q[i] <= wdata_q;
                end
            end
        end
    end

    always_comb begin
        ctrl_out  = rf_q[3];
        dbg_state = state_q;
    end

endmodule
